rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised, registered N:1 channel multiplexer with valid/ready handshaking on every input and on the output. It replaces hard-wired 4:1 select logic in datapaths where several sources share one sink. Channel selection is either fixed, driven by a select input, or round-robin arbitrated. The output is a single registered stage, so the block also breaks the timing path between sources and sink.

## Interface

Parameters:
- `NCH`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel.
- `SELW`, default `$clog2(NCH)`: derived select width; never overridden.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_data`  in  NCH*W: channel i occupies bits [i*W +: W].
- `in_valid`  in  NCH: per-channel valid.
- `in_ready`  out  NCH: per-channel ready; at most one bit high.
- `mode`  in  1: 0 = fixed (use `sel`), 1 = round-robin.
- `sel`  in  SELW: channel choice in fixed mode; a value ≥ NCH selects no channel.
- `out_data`  out  W: registered data.
- `out_valid`  out  1: output register holds a beat.
- `out_ready`  in  1: sink accepts.
- `out_ch`  out  SELW: source channel of the beat in `out_data`.

## Operation

- Output register has two states, EMPTY and FULL. The register can load when `load_ok` is true: state is EMPTY, or `out_valid && out_ready`.
- Grant, fixed mode: grant = `sel` if `sel` < NCH, otherwise no grant.
- Grant, round-robin mode: grant = the first i with `in_valid[i]`, searching upward from `rr_ptr` with wrap-around.
- `in_ready[g]` = `load_ok` for the granted channel g. All other `in_ready` bits are 0.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. It must not depend on anything else from the channel's own path.
- Transfer on channel g: `in_valid[g] && in_ready[g]`. The register loads `in_data[g]` and `out_ch` loads g. State becomes or stays FULL.
- Simultaneous output drain and input load: back-to-back, no bubble.
- Drain with no input transfer: state goes to EMPTY.
- `rr_ptr` becomes (g+1) mod NCH after each accepted transfer in round-robin mode. It is unchanged in fixed mode.
- A `mode` change takes effect at the next grant evaluation. A beat already held in the output register is unaffected.
- `out_data` and `out_ch` stay stable while `out_valid && !out_ready`.
- Reset mid-operation: a held beat is discarded. Sources must re-present any beat they did not see accepted.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `rr_ptr`=0, state EMPTY.
- While `rst_n`=0, every `in_ready` bit is 0.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- The arbiter is purely combinational between registers. The only sequential elements are the output register, `out_ch`, the state bit, `rr_ptr` and the lock state.

## Configuration

- Macro `RR_MUX_LOCK_EN`, when defined:
  - Adds port `in_last` (in, NCH) and port `out_last` (out, 1). `out_last` is registered alongside the data.
  - Adds a lock state, LOCKED/FREE. The grant holds on the current channel, ignoring `mode`/`sel` changes and `rr_ptr`, until that channel transfers a beat with `in_last`=1.
  - `rr_ptr` advances only on that last beat.
  - Reset state is FREE; `out_last` resets to 0.
- Macro not defined: there are no `in_last`/`out_last` ports, and arbitration is per beat.

## Structure

- Package `rr_mux_pkg` holds:
  - `typedef enum logic {MODE_FIXED, MODE_RR} mode_e`
  - `typedef enum logic {ST_EMPTY, ST_FULL} ost_e`
  - the maximum-NCH constant, 16.
- One sub-module, `rr_arbiter`: a rotating-priority one-hot grant. Inputs are `req[NCH]` and `ptr[SELW]`. Outputs are `gnt[NCH]`, `gnt_idx[SELW]` and `any`. It is purely combinational.

## Test plan

- Reset and fixed mode: assert reset with all inputs valid, then release with `mode`=0, `sel`=2, `in_data` ch2=0xA5 and `out_ready`=1.
  - During reset: `out_valid`=0 and `in_ready`=0.
  - Required response: `in_ready`=4'b0100, and `out_data`=0xA5, `out_ch`=2 one cycle after the transfer.
- Round-robin fairness: `mode`=1, all 4 channels valid continuously, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0,… with one beat per cycle.
- Sparse round-robin: only ch1 and ch3 valid → grants alternate 1,3,1,3.
  - Then drop ch3: ch1 is granted every cycle.
- Backpressure: `out_ready`=0 for 5 cycles while FULL → `out_data`/`out_ch` stable, `in_ready` all 0.
  - When `out_ready` rises: drain and load occur in the same cycle.
- Out-of-range select and mode switch:
  - `sel`=NCH in fixed mode → no grant and `out_valid` drops after drain.
  - Switch to `mode`=1 → grant resumes from `rr_ptr` at the next cycle.
- Lock (`RR_MUX_LOCK_EN` defined): ch0 sends 3 beats, the third with `in_last`=1, while ch1 is valid throughout → ch0 is granted 3 times, then ch1, and `out_last`=1 is seen on the third beat only.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and limits for the rr_mux_n channel multiplexer
// Contents: mode_e (fixed / round-robin), ost_e (output register EMPTY / FULL), MAX_NCH.
package rr_mux_pkg;
    typedef enum logic {MODE_FIXED, MODE_RR} mode_e;
    typedef enum logic {ST_EMPTY, ST_FULL} ost_e;
    localparam int MAX_NCH = 16;
endpackage

// File: rtl/rr_mux_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter with one-hot grant
// Ports: req (request per channel), ptr (highest-priority channel),
//        gnt (one-hot grant), gnt_idx (granted index), any (some request granted).
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);
    // Walk offsets from the far end back to ptr so the last hit is the
    // first requester at or after ptr (wrapping), without needing a break.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NCH]) begin
                gnt                         = '0;
                gnt[(int'(ptr) + k) % NCH]  = 1'b1;
                gnt_idx                     = SELW'((int'(ptr) + k) % NCH);
                any                         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N:1 valid/ready channel mux with fixed or round-robin selection
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready per channel;
//        mode (0 fixed via sel, 1 round-robin), sel; out_data/out_valid/out_ready/out_ch.
// Macro RR_MUX_LOCK_EN adds in_last/out_last and holds the grant on one channel
// until it transfers a beat marked last.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [NCH-1:0]   in_last,
    output logic             out_last,
`endif
    output logic [SELW-1:0]  out_ch
);
    ost_e            state;
    logic [SELW-1:0] rr_ptr;
    logic [NCH-1:0]  rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;
    logic [SELW-1:0] g;
    logic            g_ok;
    logic [NCH-1:0]  onehot;
    logic            load_ok;
    logic            xfer;
    logic            adv;
    logic            is_rr;
`ifdef RR_MUX_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    assign is_rr     = mode_e'(mode) == MODE_RR;
    assign out_valid = state == ST_FULL;
    assign load_ok   = state == ST_EMPTY || (out_valid && out_ready);

    // A locked channel overrides both mode and sel until its last beat.
    always_comb begin
        g      = is_rr ? rr_idx : sel;
        g_ok   = is_rr ? rr_any : (int'(sel) < NCH);
        onehot = is_rr ? rr_gnt : (NCH'(1) << sel);
`ifdef RR_MUX_LOCK_EN
        g      = locked ? lock_ch : g;
        g_ok   = locked | g_ok;
        onehot = locked ? (NCH'(1) << lock_ch) : onehot;
`endif
    end

    // rst_n gating keeps every ready low while the block is held in reset.
    assign in_ready = (rst_n && g_ok && load_ok) ? onehot : '0;
    assign xfer     = g_ok && load_ok && in_valid[g];
`ifdef RR_MUX_LOCK_EN
    assign adv      = is_rr && in_last[g];
`else
    assign adv      = is_rr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
`ifdef RR_MUX_LOCK_EN
            locked   <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                state    <= ST_FULL;
                out_data <= in_data[int'(g)*W +: W];
                out_ch   <= g;
                if (adv)
                    rr_ptr <= (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;
`ifdef RR_MUX_LOCK_EN
                // Every transfer re-evaluates the lock: a non-last beat holds
                // (or takes) the channel, a last beat releases it.
                locked   <= !in_last[g];
                lock_ch  <= g;
                out_last <= in_last[g];
`endif
            end else if (out_valid && out_ready) begin
                state <= ST_EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: self-checking bench for rr_mux_n (vector table, corner sequences, random vs model)
module tb_rr_mux_n;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready;
    logic [1:0]     out_ch;
    logic [39:0]    e_data;
    logic [4:0]     e_valid, e_ready;
    logic           e_mode;
    logic [2:0]     e_sel;
    logic [7:0]     e_odata;
    logic           e_ovalid, e_oready;
    logic [2:0]     e_och;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
    logic [4:0]     e_last;
    logic           e_olast;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_mux_n #(.NCH(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .out_ch(out_ch)
    );

    rr_mux_n #(.NCH(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(e_data), .in_valid(e_valid), .in_ready(e_ready),
        .mode(e_mode), .sel(e_sel), .out_data(e_odata), .out_valid(e_ovalid), .out_ready(e_oready),
`ifdef RR_MUX_LOCK_EN
        .in_last(e_last), .out_last(e_olast),
`endif
        .out_ch(e_och)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: output register contents, round-robin pointer, lock.
    bit        m_full;
    logic [7:0] m_data;
    int        m_ch, m_ptr;
    bit        m_locked;
    int        m_lch;

    task automatic model_reset();
        m_full = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_locked = 0; m_lch = 0;
    endtask

    task automatic model_grant(output bit ok, output int g);
        ok = 0;
        g  = 0;
        if (m_locked) begin
            ok = 1;
            g  = m_lch;
        end else if (mode) begin
            for (int k = N - 1; k >= 0; k--)
                if (in_valid[(m_ptr + k) % N]) begin
                    ok = 1;
                    g  = (m_ptr + k) % N;
                end
        end else if (int'(sel) < N) begin
            ok = 1;
            g  = int'(sel);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        v;
        logic [1:0]  ch;
        logic [7:0]  dat;
    } vec_t;

    vec_t vt[5];

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit ok;
        int g;
        bit lok, lst;
        logic [7:0] exp_d;
        vt[0] = '{2'd0, 4'b1111, 32'h44332211, 4'b0001, 1'b1, 2'd0, 8'h11};
        vt[1] = '{2'd3, 4'b1000, 32'h44332211, 4'b1000, 1'b1, 2'd3, 8'h44};
        vt[2] = '{2'd1, 4'b0001, 32'h44332211, 4'b0010, 1'b0, 2'd3, 8'h44};
        vt[3] = '{2'd2, 4'b0100, 32'hDEADBEEF, 4'b0100, 1'b1, 2'd2, 8'hAD};
        vt[4] = '{2'd1, 4'b1010, 32'hDEADBEEF, 4'b0010, 1'b1, 2'd1, 8'hBE};

        in_data = 32'h00A50000; in_valid = 4'hF; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        e_data = '0; e_valid = '0; e_mode = 1'b0; e_sel = '0; e_oready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        in_last = '1; e_last = '1;
`endif
        // Reset with every channel valid
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        rst_n = 1'b1;
        #1 chk("fixed_in_ready", in_ready, 4'b0100);
        @(negedge clk);
        chk("fixed_out_valid", out_valid, 1);
        chk("fixed_out_data", out_data, 8'hA5);
        chk("fixed_out_ch", out_ch, 2);

        // Fixed-mode vector table, sink always ready
        for (int i = 0; i < 5; i++) begin
            sel = vt[i].sel; in_valid = vt[i].valid; in_data = vt[i].data;
            #1 chk($sformatf("vec%0d_ready", i), in_ready, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].v);
            if (vt[i].v) begin
                chk($sformatf("vec%0d_ch", i), out_ch, vt[i].ch);
                chk($sformatf("vec%0d_data", i), out_data, vt[i].dat);
            end
        end

        // Round-robin fairness, all valid
        mode = 1'b1; in_valid = 4'hF; in_data = 32'h44332211;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_valid", out_valid, 1);
            chk($sformatf("rr_ch%0d", i), out_ch, i % 4);
            chk("rr_data", out_data, 8'h11 * ((i % 4) + 1));
        end

        // Sparse: ch1 and ch3 alternate, then ch1 alone
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sparse_ch%0d", i), out_ch, (i % 2) ? 3 : 1);
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("solo_ch", out_ch, 1);
            chk("solo_valid", out_valid, 1);
        end

        // Backpressure while FULL
        out_ready = 1'b0; in_data = 32'h44335C11;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h22);
            chk("bp_ch", out_ch, 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 4'b0010);
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_data", out_data, 8'h5C);

        // Out-of-range select and mode switch on a 5-channel instance
        e_valid = 5'h1F; e_data = 40'h5544332211; e_sel = 3'd1;
        #1 chk("e_sel1_ready", e_ready, 5'b00010);
        @(negedge clk);
        chk("e_sel1_valid", e_ovalid, 1);
        chk("e_sel1_ch", e_och, 1);
        chk("e_sel1_data", e_odata, 8'h22);
        e_sel = 3'd5;
        #1 chk("e_oor_ready", e_ready, 0);
        @(negedge clk);
        chk("e_oor_valid", e_ovalid, 0);
        e_mode = 1'b1;
        #1 chk("e_rr_ready", e_ready, 5'b00001);
        @(negedge clk);
        chk("e_rr_valid", e_ovalid, 1);
        chk("e_rr_ch", e_och, 0);
        chk("e_rr_data", e_odata, 8'h11);

        // Randomised traffic against the model
        reset_all();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", out_valid, m_full);
            if (m_full) begin
                chk("rnd_data", out_data, m_data);
                chk("rnd_ch", out_ch, m_ch);
            end
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom);
            in_data = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
`ifdef RR_MUX_LOCK_EN
            in_last = 4'($urandom);
`endif
            #1;
            model_grant(ok, g);
            lok = !m_full || out_ready;
            chk("rnd_in_ready", in_ready, (ok && lok) ? (4'b0001 << g) : 4'b0000);
            if (ok && lok && in_valid[g]) begin
                m_full = 1;
                m_data = in_data[g*W +: W];
                m_ch = g;
`ifdef RR_MUX_LOCK_EN
                lst = in_last[g];
                m_locked = !lst;
                m_lch = g;
`else
                lst = 1;
`endif
                if (mode && lst) m_ptr = (g + 1) % N;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
            @(negedge clk);
        end

`ifdef RR_MUX_LOCK_EN
        // Packet lock: ch0 sends three beats while ch1 waits
        reset_all();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0011;
        in_data = 32'h00007710; in_last = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk($sformatf("lock_ch%0d", b), out_ch, (b < 3) ? 0 : 1);
            if (b < 3) begin
                chk($sformatf("lock_last%0d", b), out_last, b == 2);
                exp_d = 8'h10 + 8'(b);
                chk($sformatf("lock_data%0d", b), out_data, exp_d);
            end
            in_data[7:0] = 8'h11 + 8'(b);
            in_last[0] = b == 1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
